// File: rtl/intan_pack.sv
// Drains the intan channel FIFOs (ch1 first, then ch0) into one framed byte stream:
// HD0 HD1 TYPE payload CHECKSUM. Runs in the fifoi read-clock domain.
module intan_pack #(
  parameter logic [15:0] TMO = 16'd1000,
  parameter logic [7:0]  HD0 = 8'h55,
  parameter logic [7:0]  HD1 = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  output logic        err,
  input  logic [1:0]  dev_type,
  input  logic [15:0] fifoi_rxd,
  input  logic [1:0]  fifoi_empty,
  output logic [1:0]  fifoi_rxen,
  output logic [7:0]  tx_d,
  output logic        tx_en,
  input  logic        tx_full,
  output logic [7:0]  so
);

  typedef enum logic [7:0] {
    S_IDLE  = 8'h01,
    S_WAIT  = 8'h02,
    S_HEAD0 = 8'h04,
    S_HEAD1 = 8'h08,
    S_TYPE  = 8'h10,
    S_RD1   = 8'h20,
    S_RD0   = 8'h40,
    S_SUM   = 8'h80,
    S_DONE  = 8'h81
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_dev;
  logic [11:0] r_rem1, r_rem0;
  logic [7:0]  r_sum;
  logic        r_err;
  logic [1:0]  r_vld;
  logic [15:0] r_tmo;
  logic [7:0]  r_tx_d;
  logic        r_tx_en;
  logic [1:0]  w_rxen;
  logic        w_starve;
  logic        w_tmo_hit;
  logic [15:0] w_tmo_nxt;

  assign w_tmo_nxt  = r_tmo + 16'd1;
  assign fifoi_rxen = w_rxen;
  assign fd         = (r_state == S_DONE);
  assign err        = r_err;
  assign tx_d       = r_tx_d;
  assign tx_en      = r_tx_en;
  assign so         = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // A read issued on the last remaining count lands on the same edge as the
  // advance, so rem==0 is enough to leave a read state.
  always_comb begin
    w_next    = r_state;
    w_rxen    = 2'b00;
    w_starve  = 1'b0;
    w_tmo_hit = 1'b0;
    case (r_state)
      S_IDLE:  w_next = S_WAIT;
      S_WAIT:  if (fs) w_next = S_HEAD0;
      S_HEAD0: if (!tx_full) w_next = S_HEAD1;
      S_HEAD1: if (!tx_full) w_next = S_TYPE;
      S_TYPE:  if (!tx_full) w_next = S_RD1;
      S_RD1: begin
        w_rxen[1] = (r_rem1 != 12'd0) && !fifoi_empty[1] && !tx_full;
        w_starve  = (r_rem1 != 12'd0) && fifoi_empty[1];
        w_tmo_hit = w_starve && (w_tmo_nxt == TMO);
        if (r_rem1 == 12'd0) w_next = S_RD0;
        else if (w_tmo_hit)  w_next = S_DONE;
      end
      S_RD0: begin
        w_rxen[0] = (r_rem0 != 12'd0) && !fifoi_empty[0] && !tx_full;
        w_starve  = (r_rem0 != 12'd0) && fifoi_empty[0];
        w_tmo_hit = w_starve && (w_tmo_nxt == TMO);
        if (r_rem0 == 12'd0) w_next = S_SUM;
        else if (w_tmo_hit)  w_next = S_DONE;
      end
      S_SUM:   if (!tx_full) w_next = S_DONE;
      S_DONE:  if (!fs) w_next = S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dev   <= 2'b00;
      r_rem1  <= 12'd0;
      r_rem0  <= 12'd0;
      r_sum   <= 8'd0;
      r_err   <= 1'b0;
      r_vld   <= 2'b00;
      r_tmo   <= 16'd0;
      r_tx_d  <= 8'd0;
      r_tx_en <= 1'b0;
    end else begin
      r_tx_en <= 1'b0;
      r_vld   <= w_rxen;
      if ((w_rxen != 2'b00) || (w_next != r_state)) r_tmo <= 16'd0;
      else if (w_starve)                            r_tmo <= w_tmo_nxt;
      if (w_tmo_hit) r_err <= 1'b1;
      case (r_state)
        S_WAIT: if (fs) begin
          r_dev  <= dev_type;
          r_rem1 <= (dev_type == 2'b00) ? 12'd0 : (dev_type == 2'b01) ? 12'h020 : 12'h040;
          r_rem0 <= (dev_type == 2'b11) ? 12'h040 : 12'd0;
          r_sum  <= 8'd0;
          r_err  <= 1'b0;
        end
        S_HEAD0: if (!tx_full) begin r_tx_en <= 1'b1; r_tx_d <= HD0; end
        S_HEAD1: if (!tx_full) begin r_tx_en <= 1'b1; r_tx_d <= HD1; end
        S_TYPE: if (!tx_full) begin
          r_tx_en <= 1'b1;
          r_tx_d  <= {6'b0, r_dev};
          r_sum   <= r_sum + {6'b0, r_dev};
        end
        S_RD1: if (w_rxen[1]) r_rem1 <= r_rem1 - 12'd1;
        S_RD0: if (w_rxen[0]) r_rem0 <= r_rem0 - 12'd1;
        S_SUM: if (!tx_full) begin r_tx_en <= 1'b1; r_tx_d <= r_sum; end
        default: ;
      endcase
      // Returning read data is written even under tx_full; downstream keeps a slot for it.
      if (r_vld[1]) begin
        r_tx_en <= 1'b1;
        r_tx_d  <= fifoi_rxd[15:8];
        r_sum   <= r_sum + fifoi_rxd[15:8];
      end else if (r_vld[0]) begin
        r_tx_en <= 1'b1;
        r_tx_d  <= fifoi_rxd[7:0];
        r_sum   <= r_sum + fifoi_rxd[7:0];
      end
    end
  end

endmodule
